// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register offsets, status bit
// positions, bit state machine encoding and the STATUS word packer.
package uart_pkg;

    localparam logic [3:0] UART_DATA_OFS = 4'h0;
    localparam logic [3:0] UART_STAT_OFS = 4'h4;

    // Register select field (address bits [3:2]) for each offset
    localparam logic [1:0] REG_DATA = UART_DATA_OFS[3:2];
    localparam logic [1:0] REG_STAT = UART_STAT_OFS[3:2];

    localparam int ST_AVAIL = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_FERR  = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Pack the STATUS register: count in the upper half, flags at the bottom
    function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                                input logic ferr,
                                                input logic ovr,
                                                input logic avail);
        status_word = {cnt, 13'h0000, ferr, ovr, avail};
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial front end: input synchroniser, baud counter and 8N1 bit state
// machine. Emits one-cycle strobes for a good byte or a framing error.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIVISOR = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_serial,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(DIVISOR + 1);
    // Start is confirmed half a bit after the falling edge; after that the
    // counter reloads DIVISOR-1 so each later sample lands one full bit later.
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIVISOR / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIVISOR - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    rx_state_e        r_state;
    rx_state_e        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             w_rx;
    logic             w_fall;
    logic             w_tick;

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_tick = (r_cnt == CNT_W'(0));

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_serial;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Bit state machine: state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bit state machine: next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) w_next = RX_START;
                else        w_next = RX_IDLE;
            end
            RX_START: begin
                if (w_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
                else        w_next = RX_START;
            end
            RX_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) w_next = RX_STOP;
                else                               w_next = RX_DATA;
            end
            RX_STOP: begin
                if (w_tick) w_next = RX_IDLE;
                else        w_next = RX_STOP;
            end
            default: w_next = RX_IDLE;
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= CNT_W'(0);
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) r_cnt <= HALF_BIT;
                end
                RX_START: begin
                    if (w_tick) begin
                        r_cnt     <= FULL_BIT;
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_shreg   <= {w_rx, r_shreg[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_cnt     <= FULL_BIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (!w_tick) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: r_cnt <= CNT_W'(0);
            endcase
        end
    end

    // Outputs: strobe at the stop-bit sample, good or bad
    always_comb begin
        o_byte = r_shreg;
        if ((r_state == RX_STOP) && w_tick) begin
            o_byte_valid = w_rx;
            o_frame_err  = ~w_rx;
        end else begin
            o_byte_valid = 1'b0;
            o_frame_err  = 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: receive FIFO, sticky error flags and the
// shared-bus register interface around the serial core.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);

    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    logic          w_byte_valid;
    logic [7:0]    w_byte;
    logic          w_frame_err;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovr;
    logic          r_ferr;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata_next;
    logic          w_sel;
    logic          w_wr;
    logic [1:0]    w_reg;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovr_set;
    logic          w_ovr_clr;
    logic          w_ferr_clr;
    logic          w_unused;

    uart_rx_core #(.DIVISOR(DIVISOR)) u_core (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_serial     (serialIn),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    assign w_unused   = ^{mem_instr, mem_wdata[31:3], mem_wdata[0],
                          mem_addr[31:4], mem_addr[1:0]};
    assign w_sel      = enable & mem_valid & ~r_ack;
    assign w_wr       = |mem_wstrb;
    assign w_reg      = mem_addr[3:2];
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == CW'(0));
    assign w_pop      = w_sel & ~w_wr & (w_reg == REG_DATA) & ~w_empty;
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge
    assign w_push_ok  = w_byte_valid & (~w_full | w_pop);
    assign w_ovr_set  = w_byte_valid & w_full & ~w_pop;
    assign w_ovr_clr  = w_sel & w_wr & (w_reg == REG_STAT) & mem_wdata[ST_OVR];
    assign w_ferr_clr = w_sel & w_wr & (w_reg == REG_STAT) & mem_wdata[ST_FERR];

    // Read data selected for the current request, captured on the ack edge
    always_comb begin
        w_rdata_next = 32'h0000_0000;
        if (!w_wr) begin
            case (w_reg)
                REG_DATA: begin
                    if (!w_empty) w_rdata_next = {24'h000000, r_mem[r_rptr]};
                    else          w_rdata_next = 32'h0000_0000;
                end
                REG_STAT: w_rdata_next = status_word(16'(r_count), r_ferr, r_ovr, ~w_empty);
                default:  w_rdata_next = 32'h0000_0000;
            endcase
        end else begin
            w_rdata_next = 32'h0000_0000;
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_byte;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set)       r_ovr <= 1'b1;
            else if (w_ovr_clr)  r_ovr <= 1'b0;
            if (w_frame_err)     r_ferr <= 1'b1;
            else if (w_ferr_clr) r_ferr <= 1'b0;
        end
    end

    // Bus acknowledge: one-cycle pulse after selection, with registered data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_ack <= w_sel;
            if (w_sel) r_rdata <= w_rdata_next;
        end
    end

    assign mem_ready = r_ack ? 1'b1 : 1'bz;
    assign mem_rdata = r_ack ? r_rdata : 32'bz;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of directed frames, hand-written
// corner sequences, and random traffic compared against a queue-based model.
module tb_uart_rx;

    localparam int CLK_HZ = 100000000;
    localparam int BAUD   = 1000000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    logic        serialIn = 1'b1;
    wire         mem_ready;
    wire  [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received bytes and sticky flags
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic [31:0] exp_stat;
        logic [31:0] exp_data;
        logic [31:0] exp_mid;
    } vec_t;
    vec_t vecs[4];

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .serialIn  (serialIn)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        return q.size() * 65536 + m_ferr * 4 + m_ovr * 2 + (q.size() > 0 ? 1 : 0);
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                      m_ovr = 1'b1;
    endtask

    function automatic logic [31:0] model_read();
        if (q.size() == 0) return 32'h0;
        return {24'h0, q.pop_front()};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serialIn = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (DIV) @(negedge clk);
        end
        serialIn = stop;
        repeat (DIV) @(negedge clk);
        serialIn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic bus(input logic [3:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = 32'hDEAD_BEEF;
        @(negedge clk);
        enable = 1'b1; mem_valid = 1'b1;
        mem_addr = {28'h0, addr}; mem_wstrb = strb; mem_wdata = wd;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                got = 1'b1;
                rd  = mem_rdata;
            end
        end
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL bus_timeout: no mem_ready for addr %h", addr);
        end
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(addr, 4'h0, 32'h0, rd);
        check(name, rd, exp);
    endtask

    task automatic wr_stat(input logic [31:0] wd);
        logic [31:0] rd;
        bus(4'h4, 4'hF, wd, rd);
        if (wd[1]) m_ovr = 1'b0;
        if (wd[2]) m_ferr = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [7:0] rb;
        logic rs;

        vecs[0] = '{8'hA5, 1'b1, 32'h0001_0001, 32'h0000_00A5, 32'h0000_0000};
        vecs[1] = '{8'h3C, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004};
        vecs[2] = '{8'h00, 1'b1, 32'h0001_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{8'hFF, 1'b1, 32'h0001_0001, 32'h0000_00FF, 32'h0000_0000};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_ready_idle", {31'h0, mem_ready === 1'b1}, 32'h0);
        rd_check("reset_status", 4'h4, 32'h0);

        // Directed frame table
        foreach (vecs[k]) begin
            send_frame(vecs[k].b, vecs[k].stop);
            model_frame(vecs[k].b, vecs[k].stop);
            rd_check($sformatf("vec%0d_status", k), 4'h4, vecs[k].exp_stat);
            rd_check($sformatf("vec%0d_data", k), 4'h0, vecs[k].exp_data);
            void'(model_read());
            rd_check($sformatf("vec%0d_status_mid", k), 4'h4, vecs[k].exp_mid);
            wr_stat(32'h6);
            rd_check($sformatf("vec%0d_status_clr", k), 4'h4, 32'h0);
        end

        // Short low glitch on an idle line is rejected as a false start
        serialIn = 1'b0;
        repeat (20) @(negedge clk);
        serialIn = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rd_check("glitch_status", 4'h4, 32'h0);

        // Overrun: 17 bytes into a 16-entry FIFO
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        rd_check("ovr_status", 4'h4, 32'h0010_0003);
        for (int i = 0; i < 16; i++) rd_check($sformatf("ovr_read%0d", i), 4'h0, model_read());
        rd_check("ovr_read_empty", 4'h0, 32'h0);
        wr_stat(32'h2);
        rd_check("ovr_cleared", 4'h4, 32'h0);

        // Empty DATA read with mem_valid held 5 cycles, enable dropped after 2
        pulses = 0;
        @(negedge clk);
        enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) enable = 1'b0;
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                pulses++;
                check("held_rdata", mem_rdata, 32'h0);
            end
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("hiz_ready", {31'h0, mem_ready === 1'b1}, 32'h0);
        check("hiz_rdata", {31'h0, (mem_rdata === 32'bz) || (mem_rdata === 32'h0)}, 32'h1);
        mem_valid = 1'b0;

        // Reset during data bit 4 of 0xF0 (line high from bit 4 onwards)
        serialIn = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialIn = (i >= 4) ? 1'b1 : 1'b0;
            if (i == 4) begin
                repeat (DIV / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (DIV / 2 - 1) @(negedge clk);
            end else begin
                repeat (DIV) @(negedge clk);
            end
        end
        serialIn = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        rd_check("midreset_status", 4'h4, 32'h0);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        rd_check("after_reset_status", 4'h4, 32'h0001_0001);
        rd_check("after_reset_data", 4'h0, model_read());

        // Random traffic against the model
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    rb = 8'($urandom_range(0, 255));
                    rs = ($urandom_range(0, 7) != 0);
                    send_frame(rb, rs);
                    model_frame(rb, rs);
                end
                2: rd_check("rand_data", 4'h0, model_read());
                default: begin
                    rd_check("rand_status", 4'h4, model_status());
                    wr_stat({29'h0, 3'($urandom_range(0, 7))});
                end
            endcase
        end
        rd_check("rand_final_status", 4'h4, model_status());
        while (q.size() > 0) rd_check("rand_drain", 4'h0, model_read());
        rd_check("rand_drained_data", 4'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
